// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: host-side control, table-write and status bundle.
// master = host/button FSM, slave = tone_sequencer.
interface tone_sequencer_if #(
  parameter int AW    = 3,
  parameter int DIV_W = 16
);
  logic             start;
  logic             stop;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DIV_W-1:0] wr_div;
  logic [7:0]       wr_dur;
  logic             busy;
  logic             done;
  logic [AW-1:0]    note_idx;
  logic             out;

  modport master (
    output start, stop, wr_en,
    output wr_addr, wr_div, wr_dur,
    input  busy, done, note_idx, out
  );

  modport slave (
    input  start, stop, wr_en,
    input  wr_addr, wr_div, wr_dur,
    output busy, done, note_idx, out
  );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a LEN-entry {div,dur} note table as a square wave
// on bus.out with a silent gap after each note.
// Ports: clk, rst (async, active high), bus (tone_sequencer_if.slave):
//   start/stop/wr_* in, busy/done/note_idx/out registered out.
// Option: define TONE_SEQ_LOOP_EN to restart from entry 0 instead of done.
module tone_sequencer #(
  parameter int LEN       = 8,
  parameter int DIV_W     = 16,
  parameter int TICK_DIV  = 12000,
  parameter int GAP_TICKS = 10
) (
  input logic             clk,
  input logic             rst,
  tone_sequencer_if.slave bus
);
  localparam int AW = $clog2(LEN);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (GAP_TICKS > 255) ? $clog2(GAP_TICKS + 1) : 8;

  localparam logic [PW-1:0] PRE_LD = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] GAP_LD = DW'(GAP_TICKS);
  localparam logic [AW-1:0] LAST   = AW'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] div_mem [LEN];
  logic [7:0]       dur_mem [LEN];
  logic [DIV_W-1:0] hp;
  logic [PW-1:0]    pre;
  logic [DW-1:0]    dcnt;
  logic [AW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic             out_q;

  logic [DIV_W-1:0] cur_div;
  logic [7:0]       cur_dur;
  logic             tick_end;
  logic             last_tick;

  // table is frozen outside IDLE, so PLAY can keep reading it
  assign cur_div   = div_mem[idx_q];
  assign cur_dur   = dur_mem[idx_q];
  assign tick_end  = (pre == '0);
  assign last_tick = tick_end && (dcnt == DW'(1));

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;
  assign bus.out      = out_q;

  always_ff @(posedge clk) begin
    if (st == S_IDLE && bus.wr_en) begin
      div_mem[bus.wr_addr] <= bus.wr_div;
      dur_mem[bus.wr_addr] <= bus.wr_dur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= S_IDLE;
      hp     <= '0;
      pre    <= '0;
      dcnt   <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (st != S_IDLE && bus.stop) begin
        st     <= S_IDLE;
        busy_q <= 1'b0;
        out_q  <= 1'b0;
      end else begin
        // shared tick prescaler / duration countdown
        if (st == S_PLAY || st == S_GAP) begin
          if (tick_end) begin
            pre  <= PRE_LD;
            dcnt <= dcnt - DW'(1);
          end else begin
            pre <= pre - PW'(1);
          end
        end
        unique case (st)
          S_IDLE: begin
            out_q <= 1'b0;
            if (bus.start && !bus.stop) begin
              st     <= S_LOAD;
              busy_q <= 1'b1;
              idx_q  <= '0;
            end
          end
          S_LOAD: begin
            if (cur_dur == 8'd0) begin
`ifdef TONE_SEQ_LOOP_EN
              if (idx_q != '0) begin
                idx_q <= '0;
              end else begin
                st     <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
`else
              st     <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
`endif
            end else begin
              st   <= S_PLAY;
              hp   <= (cur_div == '0) ? '0
                                      : cur_div - DIV_W'(1);
              pre  <= PRE_LD;
              dcnt <= DW'(cur_dur);
            end
          end
          S_PLAY: begin
            if (last_tick) begin
              st    <= S_GAP;
              out_q <= 1'b0;
              pre   <= PRE_LD;
              dcnt  <= GAP_LD;
            end else if (cur_div != '0) begin
              if (hp == '0) begin
                out_q <= ~out_q;
                hp    <= cur_div - DIV_W'(1);
              end else begin
                hp <= hp - DIV_W'(1);
              end
            end
          end
          S_GAP: begin
            if (last_tick) begin
              if (idx_q == LAST) begin
`ifdef TONE_SEQ_LOOP_EN
                st    <= S_LOAD;
                idx_q <= '0;
`else
                st     <= S_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
`endif
              end else begin
                st    <= S_LOAD;
                idx_q <= idx_q + AW'(1);
              end
            end
          end
          S_DONE: begin
            st <= S_IDLE;
          end
          default: begin
            st     <= S_IDLE;
            busy_q <= 1'b0;
            out_q  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: per-cycle trace model of tone_sequencer,
// directed cases plus randomized tables, writes, stops and resets.
module tb_tone_sequencer;
  localparam int LEN       = 4;
  localparam int DIV_W     = 16;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int AW        = $clog2(LEN);

  logic clk = 1'b0;
  logic rst = 1'b1;

  tone_sequencer_if #(.AW(AW), .DIV_W(DIV_W)) bus ();

  tone_sequencer #(
    .LEN(LEN),
    .DIV_W(DIV_W),
    .TICK_DIV(TICK_DIV),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
    logic          out;
    logic          chk_idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   fails    = 0;
  int   pos      = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  bit   chk_en   = 1'b0;
  int   m_div[LEN];
  int   m_dur[LEN];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, req);
    end
  endtask

  function automatic void push(bit b, bit d, int i, bit o);
    exp_t e;
    e.busy    = b;
    e.done    = d;
    e.idx     = AW'(i);
    e.out     = o;
    e.chk_idx = 1'b1;
    exp_q.push_back(e);
  endfunction

  // expected output per cycle, starting with the cycle after start
  task automatic gen_trace();
    int idx = 0;
    exp_q.delete();
    for (int g = 0; g < 64; g++) begin
      push(1, 0, idx, 0);
      if (m_dur[idx] == 0) begin
`ifdef TONE_SEQ_LOOP_EN
        if (idx != 0) begin
          idx = 0;
          continue;
        end
`endif
        push(0, 1, idx, 0);
        return;
      end
      for (int c = 0; c < m_dur[idx] * TICK_DIV; c++)
        push(1, 0, idx,
             (m_div[idx] != 0) ? ((c / m_div[idx]) % 2 == 1) : 1'b0);
      for (int c = 0; c < GAP_TICKS * TICK_DIV; c++)
        push(1, 0, idx, 0);
      if (idx == LEN - 1) begin
`ifdef TONE_SEQ_LOOP_EN
        idx = 0;
        continue;
`else
        push(0, 1, idx, 0);
        return;
`endif
      end
      idx++;
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en) begin
      e = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pos++;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("done", 32'(bus.done), 32'(e.done));
      chk("out", 32'(bus.out), 32'(e.out));
      if (e.chk_idx)
        chk("note_idx", 32'(bus.note_idx), 32'(e.idx));
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic put(int a, int dv, int du);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_div  = DIV_W'(dv);
    bus.wr_dur  = 8'(du);
    m_div[a]    = dv;
    m_dur[a]    = du;
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic kick(bit w, int a, int dv, int du);
    if (w) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_div  = DIV_W'(dv);
      bus.wr_dur  = 8'(du);
      m_div[a]    = dv;
      m_dur[a]    = du;
    end
    gen_trace();
    pos       = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    bus.start = 1'b1;
  endtask

  task automatic run(int stop_at, int rst_at, int junk_at);
    int n = 0;
    while (exp_q.size() > 0 && n < 4000) begin
      @(negedge clk); #1;
      n++;
      idle_inputs();
      if (pos - 1 == junk_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'($urandom_range(0, LEN - 1));
        bus.wr_div  = DIV_W'($urandom_range(1, 9));
        bus.wr_dur  = 8'($urandom_range(1, 5));
        bus.start   = 1'b1;
      end
      if (pos - 1 == stop_at) begin
        bus.stop = 1'b1;
        exp_q.delete();
      end
      if (pos - 1 == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_out", 32'(bus.out), 0);
        chk("arst_idx", 32'(bus.note_idx), 0);
        chk("arst_done", 32'(bus.done), 0);
        exp_q.delete();
      end
    end
    chk("trace_timeout", 32'(exp_q.size()), 0);
    @(negedge clk); #1;
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    int quiet;
    int sz;
    int st_at;
    int jk_at;
    bit w;
    bus.wr_addr = '0;
    bus.wr_div  = '0;
    bus.wr_dur  = '0;
    idle_inputs();
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_idx", 32'(bus.note_idx), 0);
    chk("rst_out", 32'(bus.out), 0);
    @(negedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < LEN; i++) put(i, 0, 0);

`ifdef TONE_SEQ_LOOP_EN
    put(0, 2, 1);
    put(1, 0, 0);
    kick(0, 0, 0, 0);
    chk("loop_model_marker", 32'(exp_q[9].idx), 1);
    chk("loop_model_wrap", 32'(exp_q[10].idx), 0);
    chk("loop_model_busy", 32'(exp_q[10].busy), 1);
    run(35, -1, -1);
    chk("loop_no_done", 32'(done_cnt), 0);
`else
    // single note then marker
    put(0, 3, 2);
    put(1, 0, 0);
    kick(0, 0, 0, 0);
    chk("t1_model_len", 32'(exp_q.size()), 15);
    chk("t1_model_rise", {exp_q[3].out, exp_q[4].out}, 32'd1);
    chk("t1_model_done", 32'(exp_q[14].done), 1);
    run(-1, -1, -1);
    chk("t1_busy_cycles", 32'(busy_cnt), 14);
    chk("t1_done_pulses", 32'(done_cnt), 1);

    // full table, no marker
    for (int i = 0; i < LEN; i++) put(i, 1, 1);
    kick(0, 0, 0, 0);
    chk("t2_model_len", 32'(exp_q.size()), 37);
    run(-1, -1, -1);
    chk("t2_busy_cycles", 32'(busy_cnt), 36);
    chk("t2_done_pulses", 32'(done_cnt), 1);

    // rest note
    put(0, 0, 3);
    put(1, 0, 0);
    kick(0, 0, 0, 0);
    quiet = 0;
    foreach (exp_q[i]) if (exp_q[i].out) quiet++;
    chk("t3_model_quiet", 32'(quiet), 0);
    run(-1, -1, -1);
    chk("t3_done_pulses", 32'(done_cnt), 1);

    // stop in 3rd PLAY cycle with write+start alongside
    put(0, 3, 2);
    put(1, 0, 0);
    kick(0, 0, 0, 0);
    run(3, -1, 3);
    chk("t4_no_done", 32'(done_cnt), 0);
    kick(0, 0, 0, 0);
    run(-1, -1, -1);
    chk("t4_replay_done", 32'(done_cnt), 1);

    // start with stop in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      idle_inputs();
    end
    chk("t4_start_stop_idle", 32'(bus.busy), 0);

    // async reset mid-GAP and mid-PLAY
    put(0, 2, 2);
    put(1, 1, 2);
    put(2, 0, 0);
    kick(0, 0, 0, 0);
    chk("t5_model_gap_idx", 32'(exp_q[23].idx), 1);
    run(-1, 23, -1);
    kick(0, 0, 0, 0);
    chk("t5_model_out_hi", 32'(exp_q[3].out), 1);
    run(-1, 3, -1);
    kick(0, 0, 0, 0);
    run(-1, -1, -1);
    chk("t5_replay_done", 32'(done_cnt), 1);
`endif

    for (int it = 0; it < 30; it++) begin
      for (int j = 0; j < int'($urandom_range(1, 4)); j++)
        put($urandom_range(0, LEN - 1), $urandom_range(0, 5),
            ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      kick(w, $urandom_range(0, LEN - 1), $urandom_range(0, 5),
           ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
      sz    = exp_q.size();
      jk_at = $urandom_range(0, sz - 1);
`ifdef TONE_SEQ_LOOP_EN
      st_at = $urandom_range(0, (sz > 150) ? 150 : sz - 1);
`else
      st_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sz - 1) : -1;
`endif
      run(st_at, -1, jk_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
